mpshare: RTL and testbench
==========================

# mpshare

Round-robin scheduler that time-shares the single 24×16 fixed-point multiplier among up to NREQ datapath clients, e.g. several upsample2x channels. Each client keeps its existing operand/product view of the multiplier. mpshare arbitrates issue slots, registers the winner's operands toward the multiplier, and tags each in-flight product with its owner. It sits between the resampler/mixer channels and the shared multiplier (mpemu in simulation).

## Interface
- NREQ, 4: number of requesters, 2..8
- MPLAT, 2: multiplier latency in cycles, from operands on mpcand_o/mplier_o to the matching product on mprod_i, 1..8
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  NREQ  per-client request; operands valid while high
- mpcand_i  in  24*NREQ  client k multiplicand at [24k+23:24k], signed
- mplier_i  in  16*NREQ  client k multiplier at [16k+15:16k], signed
- gnt_o  out  NREQ  one-hot; operands of client k captured at the closing edge
- done_o  out  NREQ  one-hot; product for client k valid on mprod_o this cycle
- mprod_o  out  24  product broadcast to all clients
- mpready_i  in  1  multiplier accepts a new operation this cycle
- mpcand_o  out  24  registered multiplicand to multiplier
- mplier_o  out  16  registered multiplier to multiplier
- mprod_i  in  24  multiplier product

## Operation
- Grant is combinational: gnt_o[k] = req_i[k] & mpready_i & (k == winner). winner is the first requester with req_i high, searching from ptr upward and wrapping.
- On an edge with gnt_o[k] high:
  - mpcand_o/mplier_o <= client k operands.
  - ptr <= (k+1) mod NREQ.
  - The tag pipeline stage 0 loads {valid=1, id=k}.
- Edge without a grant:
  - mpcand_o/mplier_o hold their last value.
  - ptr holds.
  - Stage 0 loads valid=0.
- Client handshake: hold req_i and stable operands until the edge at which gnt_o is high. After that edge, either drop req_i or present the next operation. Back-to-back grants to one client are legal when it is the only requester.
- Tag pipeline: MPLAT stages. It always advances and is not stalled by mpready_i, because the multiplier is fixed-latency. Output stage valid/id drives done_o as one-hot. mprod_o = mprod_i combinationally.
- Fairness: a client holding req_i is granted within NREQ issue slots in which mpready_i is high.
- mpready_i low: no grant. Operands and ptr hold. In-flight tags still drain.
- Signedness is not interpreted. The block only routes bits.

## Timing
- Throughput: one issue per cycle while mpready_i is high.
- Grant edge E, operands on mpcand_o during cycle E+1. done_o[k] high and mprod_o valid in cycle E+1+MPLAT, for exactly one cycle.
- Reset values:
  - ptr=0, all tag stages invalid.
  - mpcand_o=0, mplier_o=0.
  - done_o=0. gnt_o=0 while rst_n is low, since gnt is masked by reset.
- Reset mid-operation: all in-flight tags are discarded and no done_o pulse appears for them. The first grant after release starts from client 0.
- Simultaneous events:
  - A done_o for client k and a new gnt_o for client k in the same cycle are legal and independent.
  - All NREQ requesting at once: grant order ptr, ptr+1, … wrapping.
- A req_i deasserted before being granted is dropped silently.

## Structure
- Package mp_pkg holds:
  - MP_CANDW=24, MP_PLIERW=16, MP_PRODW=24.
  - MP_IDW = clog2 of the maximum NREQ (8), i.e. 3.
  - The tag struct {valid, id}.
- Sub-module rr_arbiter (NREQ): inputs req vector, enable, ptr; outputs one-hot grant and encoded winner id. It is combinational and separately unit-testable.
- mpshare itself holds the operand mux/registers, ptr, and the tag shift register.

## Test plan
- Single client: req_i=4'b0001, mpcand_i[0]=24'h010000, mplier_i[0]=16'h4000, MPLAT=2.
  - gnt_o=0001 in cycle 0.
  - done_o=0001 in cycle 3 with mprod_o equal to the multiplier model product.
  - No other done pulses.
- All four clients held high continuously: grants 0,1,2,3,0,1,… one per cycle. done_o follows the same order MPLAT+1 cycles later, and each mprod_o matches the owner's operands.
- mpready_i low for 5 cycles with req_i=1111:
  - gnt_o stays 0 and ptr holds.
  - Previously issued tags still produce done_o on schedule.
  - Granting resumes at the held ptr.
- Clients 1 and 3 requesting, with ptr=2 after granting client 1: next grant is 3, then 1. Fairness holds; no client waits more than NREQ slots.
- rst_n asserted 1 cycle after two grants:
  - No done_o pulses follow.
  - mpcand_o=0, mplier_o=0.
  - After release, client 0 wins when req_i=1111.
- Integration: two upsample2x instances with the mpemu model and MPLAT=mpemu latency. Output streams are bit-identical to each instance run alone on a dedicated multiplier.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared widths and the in-flight tag type for the multiplier-sharing scheduler.
package mp_pkg;
    localparam int MP_CANDW   = 24;
    localparam int MP_PLIERW  = 16;
    localparam int MP_PRODW   = 24;
    localparam int MP_MAXREQ  = 8;
    localparam int MP_IDW     = $clog2(MP_MAXREQ);

    typedef struct packed {
        logic              valid;
        logic [MP_IDW-1:0] id;
    } mp_tag_t;

    // Round-robin successor of a client id, wrapping at nreq.
    function automatic logic [MP_IDW-1:0] mp_next_id(input logic [MP_IDW-1:0] id,
                                                     input int nreq);
        return (int'(id) == nreq - 1) ? '0 : id + MP_IDW'(1);
    endfunction
endpackage

// File: rtl/mpshare_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// otherwise the lowest requester (wrap-around). Grant is masked by en.
module rr_arbiter
    import mp_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]   req,
    input  logic              en,
    input  logic [MP_IDW-1:0] ptr,
    output logic [NREQ-1:0]   gnt,
    output logic [MP_IDW-1:0] id
);
    logic              found_hi;
    logic              found_lo;
    logic [MP_IDW-1:0] id_hi;
    logic [MP_IDW-1:0] id_lo;
    logic              any_req;

    // Scanning downward leaves the lowest match in each half of the search.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        id_hi    = '0;
        id_lo    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                found_lo = 1'b1;
                id_lo    = MP_IDW'(k);
                if (MP_IDW'(k) >= ptr) begin
                    found_hi = 1'b1;
                    id_hi    = MP_IDW'(k);
                end
            end
        end
    end

    assign id      = found_hi ? id_hi : id_lo;
    assign any_req = found_hi | found_lo;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt[gi] = en & any_req & (id == MP_IDW'(gi));
        end
    endgenerate
endmodule

// File: rtl/mpshare.sv
// Round-robin time-sharing of one fixed-latency multiplier among NREQ clients:
// registers the winner's operands and tags each product with its owner.
module mpshare
    import mp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int MPLAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_i,
    input  logic [MP_CANDW*NREQ-1:0]   mpcand_i,
    input  logic [MP_PLIERW*NREQ-1:0]  mplier_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic [NREQ-1:0]            done_o,
    output logic [MP_PRODW-1:0]        mprod_o,
    input  logic                       mpready_i,
    output logic [MP_CANDW-1:0]        mpcand_o,
    output logic [MP_PLIERW-1:0]       mplier_o,
    input  logic [MP_PRODW-1:0]        mprod_i
);
    logic [MP_IDW-1:0]    ptr_reg;
    logic [MP_IDW-1:0]    win_id;
    logic [NREQ-1:0]      gnt;
    logic                 issue;
    logic [MP_CANDW-1:0]  cand_next;
    logic [MP_PLIERW-1:0] plier_next;
    logic [MP_CANDW-1:0]  cand_reg;
    logic [MP_PLIERW-1:0] plier_reg;

    // Stage 0 travels with the operand register; stages 1..MPLAT track the multiplier.
    mp_tag_t tag_reg [MPLAT+1];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_i),
        .en  (mpready_i & rst_n),
        .ptr (ptr_reg),
        .gnt (gnt),
        .id  (win_id)
    );

    assign gnt_o = gnt;
    assign issue = |gnt;

    always_comb begin
        cand_next  = '0;
        plier_next = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                cand_next  = mpcand_i[k*MP_CANDW +: MP_CANDW];
                plier_next = mplier_i[k*MP_PLIERW +: MP_PLIERW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            cand_reg  <= '0;
            plier_reg <= '0;
            for (int s = 0; s <= MPLAT; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            if (issue) begin
                cand_reg  <= cand_next;
                plier_reg <= plier_next;
                ptr_reg   <= mp_next_id(win_id, NREQ);
            end
            // The tag pipe never stalls: the multiplier has fixed latency.
            tag_reg[0] <= {issue, win_id};
            for (int s = 1; s <= MPLAT; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    assign mpcand_o = cand_reg;
    assign mplier_o = plier_reg;
    assign mprod_o  = mprod_i;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_done
            assign done_o[gi] = tag_reg[MPLAT].valid & (tag_reg[MPLAT].id == MP_IDW'(gi));
        end
    endgenerate
endmodule

// File: tb/tb_mpshare.sv
// Randomized bench for mpshare: a cycle-level reference scheduler predicts
// grants, operand registers and tagged done pulses against a model multiplier.
module tb_mpshare;
    localparam int NREQ  = 4;
    localparam int MPLAT = 2;
    localparam int RING  = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_i;
    logic [24*NREQ-1:0]   mpcand_i;
    logic [16*NREQ-1:0]   mplier_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      done_o;
    logic [23:0]          mprod_o;
    logic                 mpready_i;
    logic [23:0]          mpcand_o;
    logic [15:0]          mplier_o;
    logic [23:0]          mprod_i;

    always #5 clk = ~clk;

    mpshare #(.NREQ(NREQ), .MPLAT(MPLAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .mpcand_i  (mpcand_i),
        .mplier_i  (mplier_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .mprod_o   (mprod_o),
        .mpready_i (mpready_i),
        .mpcand_o  (mpcand_o),
        .mplier_o  (mplier_o),
        .mprod_i   (mprod_i)
    );

    function automatic logic [23:0] mul_fn(input logic [23:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 24'(p >>> 15);
    endfunction

    // Fixed-latency multiplier model (stands in for mpemu).
    logic [23:0] mul_pipe [MPLAT];
    always @(posedge clk) begin
        mul_pipe[0] <= mul_fn(mpcand_o, mplier_o);
        for (int i = 1; i < MPLAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign mprod_i = mul_pipe[MPLAT-1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state.
    int          m_ptr;
    logic [23:0] m_cand;
    logic [15:0] m_plier;
    logic        ex_v  [RING];
    int          ex_id [RING];
    logic [23:0] ex_p  [RING];
    int          cyc;

    task automatic clear_model();
        m_ptr   = 0;
        m_cand  = '0;
        m_plier = '0;
        for (int i = 0; i < RING; i++) ex_v[i] = 1'b0;
    endtask

    task automatic new_op(input int k);
        mpcand_i[k*24 +: 24] = 24'($urandom);
        mplier_i[k*16 +: 16] = 16'($urandom);
    endtask

    // Check one cycle at the falling edge, then advance the model over the rising edge.
    task automatic eval_cycle(output int win);
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ-1:0] exp_done;
        int slot;
        int k;
        @(negedge clk);
        win = -1;
        exp_gnt = '0;
        if (rst_n && mpready_i) begin
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (win < 0 && req_i[k]) win = k;
            end
        end
        if (win >= 0) exp_gnt[win] = 1'b1;
        check_val("gnt", 32'(gnt_o), 32'(exp_gnt));

        slot = cyc % RING;
        exp_done = '0;
        if (ex_v[slot]) exp_done[ex_id[slot]] = 1'b1;
        check_val("done", 32'(done_o), 32'(exp_done));
        if (ex_v[slot]) begin
            check_val("prod", 32'(mprod_o), 32'(ex_p[slot]));
            $display("cycle %0d: done client %0d prod %06h", cyc, ex_id[slot], mprod_o);
        end
        check_val("cand", 32'(mpcand_o), 32'(m_cand));
        check_val("plier", 32'(mplier_o), 32'(m_plier));
        ex_v[slot] = 1'b0;

        if (win >= 0) begin
            m_cand  = mpcand_i[win*24 +: 24];
            m_plier = mplier_i[win*16 +: 16];
            m_ptr   = (win + 1) % NREQ;
            slot = (cyc + 1 + MPLAT) % RING;
            ex_v[slot]  = 1'b1;
            ex_id[slot] = win;
            ex_p[slot]  = mul_fn(m_cand, m_plier);
        end
        @(posedge clk);
        cyc++;
    endtask

    // mode 0: granted client presents a new op; 1: random traffic; 2: granted client drops req.
    task automatic run_cycles(input int n, input int mode, input int rdy_pct);
        int w;
        for (int c = 0; c < n; c++) begin
            mpready_i = ($urandom_range(99) < rdy_pct);
            eval_cycle(w);
            #1;
            if (w >= 0) begin
                if (mode == 0 || (mode == 1 && $urandom_range(1) == 1)) new_op(w);
                else req_i[w] = 1'b0;
            end
            if (mode == 1) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (k != w && !req_i[k] && $urandom_range(2) == 0) begin
                        req_i[k] = 1'b1;
                        new_op(k);
                    end else if (k != w && req_i[k] && $urandom_range(19) == 0) begin
                        req_i[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        int w;
        req_i     = '0;
        mpcand_i  = '0;
        mplier_i  = '0;
        mpready_i = 1'b0;
        cyc       = 0;
        clear_model();

        // Reset state
        for (int i = 0; i < 3; i++) eval_cycle(w);
        #1 rst_n = 1'b1;

        // Single client, known operands
        req_i = 4'b0001;
        mpcand_i[23:0] = 24'h010000;
        mplier_i[15:0] = 16'h4000;
        run_cycles(6, 2, 100);

        // All four clients continuously requesting
        req_i = '1;
        for (int k = 0; k < NREQ; k++) new_op(k);
        run_cycles(12, 0, 100);

        // Multiplier not ready for 5 cycles, then resume at the held ptr
        run_cycles(5, 0, 0);
        run_cycles(6, 0, 100);

        // Clients 1 and 3 only, after client 1 was granted (ptr=2)
        req_i = 4'b0010;
        new_op(1);
        run_cycles(1, 2, 100);
        req_i = 4'b1010;
        new_op(1);
        new_op(3);
        run_cycles(6, 0, 100);

        // Reset one cycle after two grants: in-flight tags are discarded
        req_i = '1;
        for (int k = 0; k < NREQ; k++) new_op(k);
        run_cycles(2, 0, 100);
        rst_n = 1'b0;
        clear_model();
        eval_cycle(w);
        #1 rst_n = 1'b1;
        run_cycles(6, 0, 100);

        // Random traffic with random multiplier back-pressure
        run_cycles(400, 1, 75);

        // Drain
        req_i = '0;
        run_cycles(MPLAT + 3, 2, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
